seq_bw_multiplier: RTL

SEQ_BW_MULTIPLIER -- requirements
Module: seq_bw_multiplier

---
 rtl/seq_bw_multiplier_if.sv | 12 +
 rtl/seq_bw_multiplier.sv | 62 ++++++
 2 files changed

// File: rtl/seq_bw_multiplier_if.sv
// seq_bw_multiplier_if: operand/result bundle for the sequential Baugh-Wooley multiplier
interface seq_bw_multiplier_if #(parameter int N = 8);
  logic start;
  logic signed_mode;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [2*N-1:0] AB;
  logic busy;
  logic done;
  modport master (output start, signed_mode, A, B, input AB, busy, done);
  modport slave (input start, signed_mode, A, B, output AB, busy, done);
endinterface

// File: rtl/seq_bw_multiplier.sv
// seq_bw_multiplier: one partial-product row per cycle, signed (Baugh-Wooley) or unsigned
module seq_bw_multiplier #(parameter int N = 8) (
  input logic clk,
  input logic rst,
  seq_bw_multiplier_if.slave bus
);
  localparam int CW = $clog2(N);
  localparam logic [N-1:0] MASK_MID = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MASK_LAST = {1'b0, {(N-1){1'b1}}};
  // 2^(2N-1) + 2^N folds all the sign-row corrections into one constant
  localparam logic [2*N-1:0] BW_K = {1'b1, {(N-2){1'b0}}, 1'b1, {N{1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [N-1:0] a_r, b_r, pp, row;
  logic sgn_r, last;
  logic [CW-1:0] cnt;
  logic [2*N-1:0] acc, addend;
  always_comb begin
    last = cnt == CW'(N-1);
    pp = a_r & {N{b_r[cnt]}};
    row = sgn_r ? pp ^ (last ? MASK_LAST : MASK_MID) : pp;
    addend = ({{N{1'b0}}, row} << cnt) + ((sgn_r && cnt == '0) ? BW_K : '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      sgn_r <= 1'b0;
      cnt <= '0;
      acc <= '0;
      bus.AB <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          a_r <= bus.A;
          b_r <= bus.B;
          sgn_r <= bus.signed_mode;
          acc <= '0;
          cnt <= '0;
          bus.busy <= 1'b1;
          state <= CALC;
        end
        CALC: begin
          acc <= acc + addend;
          cnt <= last ? cnt : cnt + 1'b1;
          state <= last ? DONE : CALC;
        end
        DONE: begin
          bus.AB <= acc;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
